// File: rtl/stg_xt_seq_if.sv
// Handshake and payload bundle between XT decode, the micro-op sequencer and the ID latch.
// The master side is the XT decode logic; the slave side is the sequencer itself.
interface stg_xt_seq_if #(
    parameter int DATA_W  = 24,
    parameter int ADDR_W  = 24,
    parameter int MAX_SEQ = 8
);
    localparam int CNT_W = $clog2(MAX_SEQ + 1);

    logic                      iw_valid;
    logic                      ow_ready;
    logic [ADDR_W-1:0]         iw_pc;
    logic [CNT_W-1:0]          iw_len;
    logic [MAX_SEQ*DATA_W-1:0] iw_uops;
    logic                      iw_flush;
    logic                      iw_stall;
    logic                      ow_valid;
    logic [ADDR_W-1:0]         ow_pc;
    logic [DATA_W-1:0]         ow_instr;
    logic                      ow_first;
    logic                      ow_last;
    logic [CNT_W-1:0]          ow_idx;
    logic                      ow_ovf;

    modport master (
        output iw_valid, iw_pc, iw_len, iw_uops, iw_flush, iw_stall,
        input  ow_ready, ow_valid, ow_pc, ow_instr, ow_first, ow_last, ow_idx, ow_ovf
    );

    modport slave (
        input  iw_valid, iw_pc, iw_len, iw_uops, iw_flush, iw_stall,
        output ow_ready, ow_valid, ow_pc, ow_instr, ow_first, ow_last, ow_idx, ow_ovf
    );
endinterface

// File: rtl/stg_xt_seq.sv
// XT-stage micro-op sequencer: takes one instruction plus its expansion list and
// emits the micro-ops one per cycle, holding off fetch while a sequence is in flight.
module stg_xt_seq #(
    parameter  int DATA_W  = 24,
    parameter  int ADDR_W  = 24,
    parameter  int MAX_SEQ = 8,
    localparam int CNT_W   = $clog2(MAX_SEQ + 1)
) (
    input  logic         iw_clk,
    input  logic         iw_rst_n,
    stg_xt_seq_if.slave  bus
);
    localparam int               IDX_W   = $clog2(MAX_SEQ);
    localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(MAX_SEQ);

    typedef enum logic {IDLE, SEQ} state_t;

    state_t              r_state, state_next;
    logic [CNT_W-1:0]    r_idx, idx_next;
    logic [CNT_W-1:0]    r_cnt, cnt_next;
    logic [ADDR_W-1:0]   r_pc_hold, pc_hold_next;
    logic [DATA_W-1:0]   r_list [0:MAX_SEQ-1];
    logic [DATA_W-1:0]   uop_slot [0:MAX_SEQ-1];
    logic                list_we;

    logic                r_valid, valid_next;
    logic [ADDR_W-1:0]   r_pc, pc_next;
    logic [DATA_W-1:0]   r_instr, instr_next;
    logic                r_first, first_next;
    logic                r_last, last_next;
    logic [CNT_W-1:0]    r_oidx, oidx_next;
    logic                r_ovf, ovf_next;

    logic                accept;
    logic                len_ovf;
    logic [CNT_W-1:0]    len_clamp;
    logic                seq_last;

    genvar gi;
    generate
        for (gi = 0; gi < MAX_SEQ; gi++) begin : g_slot
            assign uop_slot[gi] = bus.iw_uops[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Ready is combinational so fetch sees backpressure in the same cycle.
    assign bus.ow_ready = iw_rst_n & ~bus.iw_flush & ~bus.iw_stall & (r_state == IDLE);
    assign accept       = bus.iw_valid & bus.ow_ready;
    assign len_ovf      = bus.iw_len > MAX_LEN;
    assign len_clamp    = len_ovf ? MAX_LEN : bus.iw_len;
    assign seq_last     = (r_idx == (r_cnt - CNT_W'(1)));

    always_comb begin
        state_next   = r_state;
        idx_next     = r_idx;
        cnt_next     = r_cnt;
        pc_hold_next = r_pc_hold;
        list_we      = 1'b0;
        valid_next   = r_valid;
        pc_next      = r_pc;
        instr_next   = r_instr;
        first_next   = r_first;
        last_next    = r_last;
        oidx_next    = r_oidx;
        ovf_next     = r_ovf;

        if (bus.iw_flush) begin
            state_next = IDLE;
            idx_next   = '0;
            cnt_next   = '0;
            valid_next = 1'b0;
            pc_next    = '0;
            instr_next = '0;
            first_next = 1'b0;
            last_next  = 1'b0;
            oidx_next  = '0;
            ovf_next   = 1'b0;
        end else if (!bus.iw_stall) begin
            case (r_state)
                IDLE: begin
                    valid_next = 1'b0;
                    if (accept && (len_clamp != '0)) begin
                        valid_next = 1'b1;
                        pc_next    = bus.iw_pc;
                        instr_next = uop_slot[0];
                        first_next = 1'b1;
                        last_next  = (len_clamp == CNT_W'(1));
                        oidx_next  = '0;
                        ovf_next   = len_ovf;
                        if (len_clamp >= CNT_W'(2)) begin
                            list_we      = 1'b1;
                            pc_hold_next = bus.iw_pc;
                            cnt_next     = len_clamp;
                            idx_next     = CNT_W'(1);
                            state_next   = SEQ;
                        end
                    end
                end
                SEQ: begin
                    valid_next = 1'b1;
                    pc_next    = r_pc_hold;
                    instr_next = r_list[r_idx[IDX_W-1:0]];
                    first_next = 1'b0;
                    last_next  = seq_last;
                    oidx_next  = r_idx;
                    ovf_next   = 1'b0;
                    if (seq_last) begin
                        state_next = IDLE;
                        idx_next   = '0;
                    end else begin
                        idx_next   = r_idx + CNT_W'(1);
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge iw_clk) begin
        if (!iw_rst_n) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_pc_hold <= '0;
            r_valid   <= 1'b0;
            r_pc      <= '0;
            r_instr   <= '0;
            r_first   <= 1'b0;
            r_last    <= 1'b0;
            r_oidx    <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_state   <= state_next;
            r_idx     <= idx_next;
            r_cnt     <= cnt_next;
            r_pc_hold <= pc_hold_next;
            r_valid   <= valid_next;
            r_pc      <= pc_next;
            r_instr   <= instr_next;
            r_first   <= first_next;
            r_last    <= last_next;
            r_oidx    <= oidx_next;
            r_ovf     <= ovf_next;
        end
    end

    // Expansion list storage carries no reset; its contents only matter once captured.
    always_ff @(posedge iw_clk) begin
        if (list_we) begin
            for (int k = 0; k < MAX_SEQ; k++) begin
                r_list[k] <= uop_slot[k];
            end
        end
    end

    assign bus.ow_valid = r_valid;
    assign bus.ow_pc    = r_pc;
    assign bus.ow_instr = r_instr;
    assign bus.ow_first = r_first;
    assign bus.ow_last  = r_last;
    assign bus.ow_idx   = r_oidx;
    assign bus.ow_ovf   = r_ovf;
endmodule

// File: tb/tb_stg_xt_seq.sv
// Directed bench for stg_xt_seq: stimulus queues the expected micro-ops, a negedge
// monitor pops one per micro-op taken downstream and compares it.
module tb_stg_xt_seq;
    localparam int DATA_W  = 24;
    localparam int ADDR_W  = 24;
    localparam int MAX_SEQ = 8;
    localparam int CNT_W   = $clog2(MAX_SEQ + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
        logic              first;
        logic              last;
        logic [CNT_W-1:0]  idx;
        logic              ovf;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t exp_q[$];

    stg_xt_seq_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_SEQ(MAX_SEQ)) bus();

    stg_xt_seq #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_SEQ(MAX_SEQ)) dut (
        .iw_clk   (clk),
        .iw_rst_n (rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic to_sample();
        @(negedge clk);
    endtask

    task automatic load(input int pc, input int len, input int base);
        bus.iw_pc  = ADDR_W'(pc);
        bus.iw_len = CNT_W'(len);
        for (int k = 0; k < MAX_SEQ; k++) begin
            bus.iw_uops[k*DATA_W +: DATA_W] = DATA_W'(base + k);
        end
    endtask

    // Queue slots 0..nkeep-1 of a sequence of effective length len.
    task automatic push_seq(input int pc, input int base, input int len, input bit ovf, input int nkeep);
        exp_t e;
        for (int k = 0; k < nkeep; k++) begin
            e.pc    = ADDR_W'(pc);
            e.instr = DATA_W'(base + k);
            e.first = (k == 0);
            e.last  = (k == len - 1);
            e.idx   = CNT_W'(k);
            e.ovf   = ovf && (k == 0);
            exp_q.push_back(e);
        end
    endtask

    // A micro-op counts as taken when it is valid and nothing holds or cancels it.
    initial begin
        exp_t e;
        exp_t got;
        forever begin
            @(negedge clk);
            if (bus.ow_valid && rst_n && !bus.iw_stall && !bus.iw_flush) begin
                got = '{pc: bus.ow_pc, instr: bus.ow_instr, first: bus.ow_first,
                        last: bus.ow_last, idx: bus.ow_idx, ovf: bus.ow_ovf};
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_uop: got pc=%h instr=%h idx=%0d, expected no micro-op",
                             got.pc, got.instr, got.idx);
                end else begin
                    e = exp_q.pop_front();
                    $display("uop pc=%h instr=%h first=%b last=%b idx=%0d ovf=%b",
                             got.pc, got.instr, got.first, got.last, got.idx, got.ovf);
                    check("uop", 64'(got), 64'(e));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.iw_valid = 1'b0;
        bus.iw_flush = 1'b0;
        bus.iw_stall = 1'b0;
        bus.iw_pc    = '0;
        bus.iw_len   = '0;
        bus.iw_uops  = '0;

        // Reset state
        to_drive();
        to_drive();
        to_sample();
        check("rst_valid", 64'(bus.ow_valid), 64'd0);
        check("rst_pc",    64'(bus.ow_pc),    64'd0);
        check("rst_instr", 64'(bus.ow_instr), 64'd0);
        check("rst_flags", 64'({bus.ow_first, bus.ow_last, bus.ow_ovf}), 64'd0);
        check("rst_idx",   64'(bus.ow_idx),   64'd0);
        check("rst_ready", 64'(bus.ow_ready), 64'd0);
        to_drive();
        rst_n = 1'b1;

        // Pass-through: three len-1 instructions back to back
        load('h10, 1, 'h123456);
        bus.iw_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_seq('h10, 'h123456, 1, 1'b0, 1);
            to_sample();
            check("pt_ready", 64'(bus.ow_ready), 64'd1);
            if (i > 0) check("pt_valid", 64'(bus.ow_valid), 64'd1);
            to_drive();
        end
        bus.iw_valid = 1'b0;
        to_sample();
        check("pt_valid_last", 64'(bus.ow_valid), 64'd1);
        to_drive();
        to_sample();
        check("pt_idle", 64'(bus.ow_valid), 64'd0);

        // Expansion: len 4, then a len-1 instruction waiting behind it
        to_drive();
        load('h40, 4, 'hA0000);
        bus.iw_valid = 1'b1;
        push_seq('h40, 'hA0000, 4, 1'b0, 4);
        to_sample();
        check("ex_ready_acc", 64'(bus.ow_ready), 64'd1);
        to_drive();
        load('h50, 1, 'hB00001);
        push_seq('h50, 'hB00001, 1, 1'b0, 1);
        for (int i = 0; i < 3; i++) begin
            to_sample();
            check("ex_ready_busy", 64'(bus.ow_ready), 64'd0);
            to_drive();
        end
        to_sample();
        check("ex_idx3", 64'(bus.ow_idx), 64'd3);
        check("ex_ready_free", 64'(bus.ow_ready), 64'd1);
        to_drive();
        bus.iw_valid = 1'b0;
        to_sample();
        check("ex_next_valid", 64'(bus.ow_valid), 64'd1);
        check("ex_next_pc", 64'(bus.ow_pc), 64'h50);

        // Stall mid-sequence: hold idx 1 for two extra cycles
        to_drive();
        load('h60, 3, 'hC0000);
        bus.iw_valid = 1'b1;
        push_seq('h60, 'hC0000, 3, 1'b0, 3);
        to_drive();
        bus.iw_valid = 1'b0;
        to_drive();
        bus.iw_stall = 1'b1;
        to_sample();
        check("st_idx_a", 64'(bus.ow_idx), 64'd1);
        to_drive();
        to_sample();
        check("st_idx_b", 64'(bus.ow_idx), 64'd1);
        to_drive();
        bus.iw_stall = 1'b0;
        to_sample();
        check("st_idx_c", 64'({bus.ow_valid, 4'(bus.ow_idx)}), 64'h11);
        to_drive();
        to_sample();
        check("st_idx2_last", 64'({bus.ow_valid, bus.ow_last, 4'(bus.ow_idx)}), 64'h32);

        // Flush with stall at idx 2 of a len-8 sequence
        to_drive();
        load('h80, 8, 'hD0000);
        bus.iw_valid = 1'b1;
        push_seq('h80, 'hD0000, 8, 1'b0, 2);
        to_drive();
        bus.iw_valid = 1'b0;
        to_drive();
        to_drive();
        bus.iw_flush = 1'b1;
        bus.iw_stall = 1'b1;
        to_sample();
        check("fl_pre_idx", 64'(bus.ow_idx), 64'd2);
        to_drive();
        bus.iw_flush = 1'b0;
        bus.iw_stall = 1'b0;
        to_sample();
        check("fl_valid", 64'(bus.ow_valid), 64'd0);
        check("fl_idx", 64'(bus.ow_idx), 64'd0);
        check("fl_ready", 64'(bus.ow_ready), 64'd1);
        to_drive();
        load('h90, 2, 'hE0000);
        bus.iw_valid = 1'b1;
        push_seq('h90, 'hE0000, 2, 1'b0, 2);
        to_drive();
        bus.iw_valid = 1'b0;
        to_sample();
        check("fl_restart_first", 64'({bus.ow_valid, bus.ow_first}), 64'h3);
        to_drive();
        to_sample();
        check("fl_restart_last", 64'({bus.ow_valid, bus.ow_last}), 64'h3);

        // Squash: len 0 is consumed and emits nothing
        to_drive();
        load('hA0, 0, 'h777000);
        bus.iw_valid = 1'b1;
        to_sample();
        check("sq_ready", 64'(bus.ow_ready), 64'd1);
        to_drive();
        bus.iw_valid = 1'b0;
        to_sample();
        check("sq_valid", 64'(bus.ow_valid), 64'd0);
        check("sq_ready_after", 64'(bus.ow_ready), 64'd1);

        // Clamp: len 12 emits exactly 8 slots, ovf on slot 0 only
        to_drive();
        load('hB0, 12, 'hF0000);
        bus.iw_valid = 1'b1;
        push_seq('hB0, 'hF0000, 8, 1'b1, 8);
        to_drive();
        bus.iw_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            to_sample();
            check("cl_idx", 64'(bus.ow_idx), 64'(i));
            to_drive();
        end
        to_sample();
        check("cl_done", 64'(bus.ow_valid), 64'd0);

        // Reset at idx 3 of a len-5 sequence
        to_drive();
        load('hC0, 5, 'h110000);
        bus.iw_valid = 1'b1;
        push_seq('hC0, 'h110000, 5, 1'b0, 3);
        to_drive();
        bus.iw_valid = 1'b0;
        to_drive();
        to_drive();
        to_drive();
        rst_n = 1'b0;
        to_sample();
        check("rm_pre_idx", 64'(bus.ow_idx), 64'd3);
        to_drive();
        rst_n = 1'b1;
        to_sample();
        check("rm_outputs", 64'({bus.ow_valid, bus.ow_first, bus.ow_last, bus.ow_ovf,
                                 4'(bus.ow_idx)}), 64'd0);
        check("rm_pc_instr", 64'({bus.ow_pc, bus.ow_instr}), 64'd0);
        check("rm_ready", 64'(bus.ow_ready), 64'd1);
        to_drive();
        to_sample();
        check("rm_quiet", 64'(bus.ow_valid), 64'd0);

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/stg_xt_seq.md
# stg_xt_seq

Parametrised micro-op sequencer for the translate (XT) stage, the successor to the fixed four-slot expander. It accepts one decoded ISA instruction together with a pre-decoded expansion list of up to `MAX_SEQ` micro-ops. It emits the list one micro-op per cycle, tagged with first/last/index and held at the originating PC, and applies real backpressure to fetch while a sequence is in flight. It sits between the XT decode logic and the ID stage latch.

## Interface
Parameters:
- `DATA_W`, 24: instruction / micro-op width.
- `ADDR_W`, 24: PC width.
- `MAX_SEQ`, 8: maximum micro-ops per expansion (≥2).
- `CNT_W`, `$clog2(MAX_SEQ+1)`: derived length/index width; never overridden.

Ports:
- `iw_clk` in 1: clock. One clock; reset is synchronous and active-low.
- `iw_rst_n` in 1: synchronous active-low reset.
- `iw_valid` in 1: upstream instruction valid.
- `ow_ready` out 1: stage accepts the instruction this cycle.
- `iw_pc` in `ADDR_W`: instruction PC.
- `iw_len` in `CNT_W`: micro-op count. 0 = squash (consume, emit nothing).
- `iw_uops` in `MAX_SEQ*DATA_W`: micro-op k at `[k*DATA_W +: DATA_W]`.
- `iw_flush` in 1: cancel in-flight sequence and output.
- `iw_stall` in 1: downstream hold.
- `ow_valid` out 1: output micro-op valid.
- `ow_pc` out `ADDR_W`: originating PC of the output micro-op.
- `ow_instr` out `DATA_W`: output micro-op.
- `ow_first` out 1: output is slot 0 of its sequence.
- `ow_last` out 1: output is the final slot of its sequence.
- `ow_idx` out `CNT_W`: slot index of the output micro-op.
- `ow_ovf` out 1: the accepted `iw_len` exceeded `MAX_SEQ` and was clamped. Registered alongside slot 0.

## Operation
- States: IDLE, SEQ. Registers: `r_state`, `r_idx`, `r_cnt`, `r_pc_hold`, `r_list[0:MAX_SEQ-1]`, output register set.
- `ow_ready = iw_rst_n & ~iw_flush & ~iw_stall & (r_state==IDLE)`. This is combinational. An accept is `iw_valid & ow_ready`.
- Update priority: reset > flush > stall > advance.
- Reset: IDLE; `r_idx`/`r_cnt` = 0. All outputs = 0 (`ow_valid`, `ow_pc`, `ow_instr`, `ow_first`, `ow_last`, `ow_idx`, `ow_ovf`). `r_list` contents are don't-care.
- Flush: IDLE; `ow_valid`/`ow_first`/`ow_last`/`ow_ovf` = 0; `ow_pc`/`ow_instr`/`ow_idx` = 0; `r_idx`/`r_cnt` = 0. No accept in the flush cycle.
- Stall: all registers hold, including the output set and sequence state.
- Advance, IDLE, no accept: `ow_valid` = 0. Other outputs hold.
- Advance, IDLE, accept:
  - Compute `len = min(iw_len, MAX_SEQ)`.
  - `len==0`: `ow_valid` = 0; stay IDLE.
  - `len>=1`: output `uops[0]` with `iw_pc`, `first=1`, `last=(len==1)`, `idx=0`, `ovf=(iw_len>MAX_SEQ)`.
  - `len>=2`: additionally capture all slots into `r_list`, `r_pc_hold=iw_pc`, `r_cnt=len`, `r_idx=1`, and go to SEQ.
- Advance, SEQ:
  - Output `r_list[r_idx]` with `r_pc_hold`, `first=0`, `ovf=0`, `idx=r_idx`, `last=(r_idx==r_cnt-1)`.
  - If last, go to IDLE and set `r_idx`=0. Otherwise increment `r_idx`.
- Slots at or above `len` are never emitted.

## Timing
- Latency: accept at edge t → slot 0 valid after t. Slot k is valid k cycles later, absent stalls.
- Back-to-back: the next instruction is accepted in the cycle after the last slot is registered. There are no bubbles between sequences, and a continuous stream of len-1 instructions gives full throughput.
- Each stall cycle adds exactly one cycle and never drops or duplicates a slot.
- Flush while in SEQ with a stall also asserted: flush wins, and `ow_valid` = 0 the next cycle.
- Reset in mid-sequence: the next cycle is IDLE with outputs 0 and `ow_ready` = 1 (no stall or flush).
- Upstream must hold `iw_*` stable while `iw_valid & ~ow_ready`.

## Test plan
- **Pass-through.** Reset, then `iw_len=1`, `uops[0]=0x123456`, `pc=0x10`, `valid`=1 for 3 cycles. Required: three consecutive `ow_valid` cycles, each `instr=0x123456`, `first=last=1`, `idx=0`, with `ow_ready` constantly 1.
- **Expansion.** `len=4`, slots 0xA0000..0xA0003, `pc=0x40`. Required:
  - Four consecutive outputs, all with `pc=0x40` and `idx` 0..3.
  - `first` only on slot 0; `last` only on slot 3.
  - `ow_ready` = 0 for 3 cycles, and the next instruction appears in the cycle immediately after slot 3.
- **Stall mid-sequence.** `len=3`; assert `iw_stall` for 2 cycles while `idx=1` is on the outputs. Required: `idx=1` is held for 3 cycles total, then `idx=2` with `last` = 1. No slot is lost.
- **Flush mid-sequence.** `len=8`; flush while `idx=2` is on the outputs, with `iw_stall` = 1 in the same cycle. Required: the next cycle shows `ow_valid` = 0 and `ow_idx` = 0, and the next accept starts with `first` = 1.
- **Squash and clamp.** `len=0` gives no `ow_valid` while the instruction is consumed. `len=12` (with `CNT_W=4`) emits exactly 8 slots with `ow_ovf` = 1 only on slot 0.
- **Reset mid-sequence.** `iw_rst_n` = 0 for 1 cycle at `idx=3`. Required: all outputs read 0, IDLE, and `ow_ready` = 1 the following cycle.
